// File: rtl/switch_box_config_loader.sv
// Writer side of the switch box configuration interface: gathers a stream of
// configuration words in a shadow register and commits the full vector atomically.
module switch_box_config_loader #(
    parameter int CONFIG_WIDTH = 384,
    parameter int WORD_WIDTH   = 32
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    cfg_start,
    input  logic [WORD_WIDTH-1:0]   cfg_data,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_done,
    output logic                    cfg_busy
);

    localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int SHADOW_W  = NUM_WORDS * WORD_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        word_cnt_r;
    logic [SHADOW_W-1:0]     shadow_r;
    logic [CONFIG_WIDTH-1:0] config_out_r;
    logic                    config_done_r;
    logic                    cfg_ready_r;
    logic                    cfg_busy_r;

    logic                    handshake_s;
    logic                    last_word_s;
    logic [SHADOW_W-1:0]     merged_s;

    assign handshake_s = cfg_valid & cfg_ready_r;
    assign last_word_s = handshake_s & (word_cnt_r == LAST_IDX);

    // Shadow contents with the word currently on the bus dropped into its slot.
    always_comb begin
        merged_s = shadow_r;
        merged_s[int'(word_cnt_r) * WORD_WIDTH +: WORD_WIDTH] = cfg_data;
    end

    // Load FSM; the final word is merged straight into config_out so the commit
    // and the last handshake share one edge.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r       <= IDLE;
            word_cnt_r    <= '0;
            shadow_r      <= '0;
            config_out_r  <= '0;
            config_done_r <= 1'b0;
            cfg_ready_r   <= 1'b0;
            cfg_busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cfg_start) begin
                        state_r     <= LOAD;
                        word_cnt_r  <= '0;
                        shadow_r    <= '0;
                        cfg_ready_r <= 1'b1;
                        cfg_busy_r  <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        // Restart wins over any word offered in the same cycle.
                        word_cnt_r <= '0;
                        shadow_r   <= '0;
                    end else if (last_word_s) begin
                        config_out_r  <= merged_s[CONFIG_WIDTH-1:0];
                        config_done_r <= 1'b1;
                        cfg_ready_r   <= 1'b0;
                        cfg_busy_r    <= 1'b0;
                        word_cnt_r    <= '0;
                        shadow_r      <= '0;
                        state_r       <= DONE;
                    end else if (handshake_s) begin
                        shadow_r   <= merged_s;
                        word_cnt_r <= word_cnt_r + CNT_ONE;
                    end else begin
                        word_cnt_r <= word_cnt_r;
                    end
                end
                DONE: begin
                    if (cfg_start) begin
                        state_r       <= LOAD;
                        word_cnt_r    <= '0;
                        shadow_r      <= '0;
                        config_done_r <= 1'b0;
                        cfg_ready_r   <= 1'b1;
                        cfg_busy_r    <= 1'b1;
                    end else begin
                        state_r       <= DONE;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    word_cnt_r    <= '0;
                    shadow_r      <= '0;
                    config_done_r <= 1'b0;
                    cfg_ready_r   <= 1'b0;
                    cfg_busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready   = cfg_ready_r;
    assign config_out  = config_out_r;
    assign config_done = config_done_r;
    assign cfg_busy    = cfg_busy_r;

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Randomized bench for switch_box_config_loader: a word-list reference model
// feeds a commit scoreboard, and a monitor compares outputs every cycle.
module tb_switch_box_config_loader;

    localparam int CW = 384;
    localparam int WW = 32;
    localparam int NW = 12;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    logic          clock = 1'b0;
    logic          nreset = 1'b0;
    logic          cfg_start = 1'b0;
    logic [WW-1:0] cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] config_out;
    logic          config_done;
    logic          cfg_busy;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    int            m_mode = M_IDLE;
    logic [WW-1:0] m_words[$];
    logic [CW-1:0] m_out = '0;
    logic          m_done = 1'b0;
    logic [CW-1:0] exp_q[$];

    switch_box_config_loader dut (
        .clock       (clock),
        .nreset      (nreset),
        .cfg_start   (cfg_start),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .config_out  (config_out),
        .config_done (config_done),
        .cfg_busy    (cfg_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: collect accepted words, commit when a full set arrives.
    initial begin
        logic [CW-1:0] vec;
        forever begin
            @(posedge clock or negedge nreset);
            if (!nreset) begin
                m_mode = M_IDLE;
                m_words.delete();
                m_out  = '0;
                m_done = 1'b0;
            end else if (cfg_start) begin
                m_mode = M_LOAD;
                m_words.delete();
                m_done = 1'b0;
            end else if (m_mode == M_LOAD && cfg_valid) begin
                m_words.push_back(cfg_data);
                if (m_words.size() == NW) begin
                    vec = '0;
                    for (int i = 0; i < NW; i++) vec[i*WW +: WW] = m_words[i];
                    m_out  = vec;
                    m_done = 1'b1;
                    m_mode = M_DONE;
                    exp_q.push_back(vec);
                end
            end
        end
    end

    // Monitor: per-cycle output comparison plus scoreboard pop on each new commit.
    initial begin
        logic          prev_done;
        logic [CW-1:0] exp_v;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            check("ready", CW'(cfg_ready), CW'(m_mode == M_LOAD));
            check("busy", CW'(cfg_busy), CW'(m_mode == M_LOAD));
            check("done", CW'(config_done), CW'(m_done));
            check("out_hold", config_out, m_out);
            if (config_done === 1'b1 && prev_done !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", CW'(1), CW'(0));
                end else begin
                    exp_v = exp_q.pop_front();
                    check("commit", config_out, exp_v);
                end
            end
            prev_done = config_done;
        end
    end

    task automatic send_word(input logic [WW-1:0] d, input int gap);
        repeat (gap) @(negedge clock);
        cfg_valid = 1'b1;
        cfg_data  = d;
        @(negedge clock);
        cfg_valid = 1'b0;
        cfg_data  = $urandom;
    endtask

    task automatic pulse_start(input logic with_valid, input logic [WW-1:0] d);
        cfg_start = 1'b1;
        cfg_valid = with_valid;
        cfg_data  = d;
        @(negedge clock);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] inc_vec;
        logic [CW-1:0] a5_vec;
        inc_vec = '0;
        for (int i = 0; i < NW; i++) inc_vec[i*WW +: WW] = WW'(i + 1);
        a5_vec = {48{8'hA5}};

        repeat (3) @(negedge clock);
        nreset = 1'b1;

        // words offered in IDLE are ignored
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_data  = $urandom;
            @(negedge clock);
        end
        cfg_valid = 1'b0;

        // full back-to-back load; start carries a word that must not be taken
        pulse_start(1'b1, 32'h5555_5555);
        for (int i = 0; i < NW; i++) send_word(WW'(i + 1), 0);
        check("first_word", CW'(config_out[31:0]), CW'(32'h1));
        check("last_word", CW'(config_out[383:352]), CW'(32'hC));
        @(negedge clock);
        check("full_done", CW'(config_done), CW'(1'b1));
        check("full_ready", CW'(cfg_ready), CW'(1'b0));

        // extra words in DONE
        cfg_valid = 1'b1;
        cfg_data  = 32'hDEAD_BEEF;
        repeat (10) @(negedge clock);
        cfg_valid = 1'b0;
        check("done_ignore_out", config_out, inc_vec);
        check("done_ignore_done", CW'(config_done), CW'(1'b1));

        // back-pressure: valid low on alternate cycles
        pulse_start(1'b0, '0);
        for (int i = 0; i < NW; i++) send_word(WW'(i + 1), 1);
        check("bp_out", config_out, inc_vec);

        // restart mid-load with a word in the restart cycle
        pulse_start(1'b0, '0);
        for (int i = 0; i < 5; i++) send_word(32'hFFFF_FFFF, 0);
        pulse_start(1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < NW; i++) send_word(32'hA5A5_A5A5, $urandom_range(0, 2));
        check("restart_out", config_out, a5_vec);

        // random loads with random stalls
        for (int l = 0; l < 3; l++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            pulse_start(1'($urandom_range(0, 1)), $urandom);
            for (int i = 0; i < NW; i++) send_word($urandom, $urandom_range(0, 3));
        end

        // reset mid-load
        pulse_start(1'b0, '0);
        for (int i = 0; i < 7; i++) send_word($urandom, 0);
        #2;
        nreset = 1'b0;
        #1;
        check("rst_out", config_out, '0);
        check("rst_done", CW'(config_done), CW'(1'b0));
        check("rst_ready", CW'(cfg_ready), CW'(1'b0));
        check("rst_busy", CW'(cfg_busy), CW'(1'b0));
        @(negedge clock);
        nreset = 1'b1;
        @(negedge clock);
        pulse_start(1'b0, '0);
        for (int i = 0; i < NW; i++) send_word($urandom, $urandom_range(0, 1));
        repeat (3) @(negedge clock);

        check("scoreboard_drain", CW'(exp_q.size()), CW'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
